// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
//  Module   : serial_to_parallel
//  Purpose  : Collects WIDTH consecutive XLEN-bit serial beats (element 0
//             first) into one WIDTH x XLEN frame. The frame appears on a
//             registered parallel output with valid/ready on both sides.
//  Option   : define SERIAL_TO_PARALLEL_FIRST_EN to add the serial_first
//             resync input and the frame_err pulse output.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel #(
   parameter int XLEN  = 8,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       serial_valid,
   input  logic [XLEN-1:0]            serial_data,
   output logic                       serial_ready,
`ifdef SERIAL_TO_PARALLEL_FIRST_EN
   input  logic                       serial_first,
   output logic                       frame_err,
`endif
   output logic                       parallel_valid,
   input  logic                       parallel_ready,
   output logic [WIDTH-1:0][XLEN-1:0] parallel_data
);

   localparam int PTR_W = $clog2(WIDTH);
   localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(WIDTH - 1);

   logic [PTR_W-1:0]                ptr_q, ptr_d;
   logic [WIDTH-2:0][XLEN-1:0]      asm_q, asm_d;
   logic [WIDTH-1:0][XLEN-1:0]      pdata_q, pdata_d;
   logic                            pvalid_q, pvalid_d;

   logic w_last;
   logic w_beat_acc;
   logic w_frame_acc;
   logic w_first_beat;

   // The final beat may only stall while an unaccepted frame still occupies
   // the output register; earlier beats land in the assembly register.
   assign w_last       = (ptr_q == C_PTR_LAST);
   assign serial_ready = !(w_last && pvalid_q && !parallel_ready);
   assign w_beat_acc   = serial_valid && serial_ready;
   assign w_frame_acc  = pvalid_q && parallel_ready;

`ifdef SERIAL_TO_PARALLEL_FIRST_EN
   logic frame_err_q, frame_err_d;

   assign w_first_beat = serial_first;
   assign frame_err    = frame_err_q;

   // A resync beat arriving mid-frame flags the discarded partial frame.
   always_comb begin
      frame_err_d = w_beat_acc && serial_first && (ptr_q != '0);
   end

   // Error pulse register, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
      end
   end
`else
   assign w_first_beat = 1'b0;
`endif

   // Next-state for pointer, assembly buffer and output frame.
   always_comb begin
      ptr_d    = ptr_q;
      asm_d    = asm_q;
      pdata_d  = pdata_q;
      pvalid_d = pvalid_q;

      if (w_frame_acc) begin
         pvalid_d = 1'b0;
      end

      if (w_beat_acc) begin
         if (w_first_beat) begin
            // Resync: this beat restarts the frame at element 0.
            asm_d[0] = serial_data;
            ptr_d    = PTR_W'(1);
         end else if (w_last) begin
            // Final beat bypasses the assembly buffer straight to the output.
            pdata_d  = {serial_data, asm_q};
            pvalid_d = 1'b1;
            ptr_d    = '0;
         end else begin
            for (int k = 0; k < WIDTH - 1; k++) begin
               if (ptr_q == PTR_W'(k)) begin
                  asm_d[k] = serial_data;
               end
            end
            ptr_d = ptr_q + PTR_W'(1);
         end
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= '0;
         pvalid_q <= 1'b0;
         pdata_q  <= '0;
      end else begin
         ptr_q    <= ptr_d;
         pvalid_q <= pvalid_d;
         pdata_q  <= pdata_d;
      end
   end

   // Assembly buffer holds data only; its contents are meaningless until written.
   always_ff @(posedge clk) begin
      asm_q <= asm_d;
   end

   assign parallel_valid = pvalid_q;
   assign parallel_data  = pdata_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_to_parallel
//  Purpose  : Self-checking bench for serial_to_parallel (WIDTH=4, XLEN=8).
//             Directed cases with literal expectations plus random
//             valid/ready traffic against a queue-based frame model.
//             Optional resync checks when SERIAL_TO_PARALLEL_FIRST_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel;

   localparam int XLEN  = 8;
   localparam int WIDTH = 4;
   localparam int FW    = WIDTH * XLEN;

   logic                       clk;
   logic                       rst;
   logic                       serial_valid;
   logic [XLEN-1:0]            serial_data;
   logic                       serial_ready;
   logic                       serial_first;
   logic                       frame_err;
   logic                       parallel_valid;
   logic                       parallel_ready;
   logic [WIDTH-1:0][XLEN-1:0] parallel_data;

   int total;
   int bad;
   bit checking;

   serial_to_parallel #(.XLEN(XLEN), .WIDTH(WIDTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .serial_valid   (serial_valid),
      .serial_data    (serial_data),
      .serial_ready   (serial_ready),
`ifdef SERIAL_TO_PARALLEL_FIRST_EN
      .serial_first   (serial_first),
      .frame_err      (frame_err),
`endif
      .parallel_valid (parallel_valid),
      .parallel_ready (parallel_ready),
      .parallel_data  (parallel_data)
   );

`ifndef SERIAL_TO_PARALLEL_FIRST_EN
   assign frame_err = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural frame model ----------------
   logic [XLEN-1:0] cur[$];      // beats collected for the frame in progress
   bit              m_pv;
   logic [FW-1:0]   m_pd;
   bit              m_ferr;
   int              n_made;
   int              n_consumed;

   function automatic bit first_in();
`ifdef SERIAL_TO_PARALLEL_FIRST_EN
      return serial_first;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit exp_ready();
      return !((cur.size() == WIDTH - 1) && m_pv && !parallel_ready);
   endfunction

   always @(posedge clk) begin
      bit acc;
      if (rst) begin
         cur.delete();
         m_pv   = 1'b0;
         m_pd   = '0;
         m_ferr = 1'b0;
      end else begin
         acc    = serial_valid && exp_ready();
         m_ferr = 1'b0;
         if (m_pv && parallel_ready) begin
            m_pv = 1'b0;
            n_consumed++;
         end
         if (acc) begin
            if (first_in()) begin
               m_ferr = (cur.size() != 0);
               cur.delete();
               cur.push_back(serial_data);
            end else begin
               cur.push_back(serial_data);
               if (cur.size() == WIDTH) begin
                  for (int i = 0; i < WIDTH; i++) m_pd[i*XLEN +: XLEN] = cur[i];
                  m_pv = 1'b1;
                  n_made++;
                  cur.delete();
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      logic [FW-1:0] flat;
      if (checking && !rst) begin
         flat = parallel_data;
         chk("cyc_serial_ready", 64'(serial_ready), 64'(exp_ready()));
         chk("cyc_parallel_valid", 64'(parallel_valid), 64'(m_pv));
         chk("cyc_parallel_data", 64'(flat), 64'(m_pd));
         chk("cyc_frame_err", 64'(frame_err), 64'(m_ferr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic setin(input bit v, input logic [XLEN-1:0] d, input bit pr, input bit f);
      serial_valid   = v;
      serial_data    = d;
      parallel_ready = pr;
      serial_first   = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [XLEN-1:0] d, input bit pr);
      setin(1'b1, d, pr, 1'b0);
      tick();
   endtask

   initial begin
      total = 0; bad = 0; checking = 1'b0;
      n_made = 0; n_consumed = 0;
      rst = 1'b1;
      setin(1'b0, '0, 1'b1, 1'b0);
      tick(); tick();
      rst = 1'b0;
      checking = 1'b1;
      #1;

      // Reset state
      chk("rst_pvalid", 64'(parallel_valid), 64'd0);
      chk("rst_pdata", 64'(parallel_data), 64'd0);
      chk("rst_sready", 64'(serial_ready), 64'd1);
      chk("rst_ferr", 64'(frame_err), 64'd0);

      // Single frame with consumer always ready
      beat(8'h11, 1'b1); beat(8'h22, 1'b1); beat(8'h33, 1'b1); beat(8'h44, 1'b1);
      chk("f1_pvalid", 64'(parallel_valid), 64'd1);
      chk("f1_pdata", 64'(parallel_data), 64'h44332211);
      setin(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      chk("f1_drop", 64'(parallel_valid), 64'd0);

      // 12-beat continuous stream: three frames, never stalled
      for (int i = 0; i < 12; i++) begin
         setin(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
         #1;
         chk("stream_sready", 64'(serial_ready), 64'd1);
         tick();
         if (i % 4 == 3) chk("stream_pvalid", 64'(parallel_valid), 64'd1);
      end
      chk("stream_last", 64'(parallel_data), 64'h3B3A3938);
      setin(1'b0, 8'h00, 1'b1, 1'b0);
      tick();

      // Backpressure: frame held, final beat of next frame stalls
      beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
      beat(8'h05, 1'b0); beat(8'h06, 1'b0); beat(8'h07, 1'b0);
      setin(1'b1, 8'h08, 1'b0, 1'b0);
      #1;
      chk("stall_sready", 64'(serial_ready), 64'd0);
      tick(); tick();
      chk("stall_hold", 64'(parallel_data), 64'h04030201);
      chk("stall_pvalid", 64'(parallel_valid), 64'd1);
      setin(1'b1, 8'h08, 1'b1, 1'b0);
      #1;
      chk("release_sready", 64'(serial_ready), 64'd1);
      tick();
      chk("release_pvalid", 64'(parallel_valid), 64'd1);
      chk("release_pdata", 64'(parallel_data), 64'h08070605);
      setin(1'b0, 8'h00, 1'b1, 1'b0);
      tick();

      // Reset mid-frame discards partial beats
      beat(8'h77, 1'b1); beat(8'h78, 1'b1);
      rst = 1'b1;
      setin(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      rst = 1'b0;
      beat(8'hA0, 1'b1); beat(8'hA1, 1'b1); beat(8'hA2, 1'b1); beat(8'hA3, 1'b1);
      chk("rst_mid_pdata", 64'(parallel_data), 64'hA3A2A1A0);
      chk("rst_mid_pvalid", 64'(parallel_valid), 64'd1);
      setin(1'b0, 8'h00, 1'b1, 1'b0);
      tick();

`ifdef SERIAL_TO_PARALLEL_FIRST_EN
      // Resync mid-frame
      beat(8'h01, 1'b1); beat(8'h02, 1'b1);
      setin(1'b1, 8'h55, 1'b1, 1'b1);
      tick();
      chk("resync_ferr", 64'(frame_err), 64'd1);
      beat(8'h66, 1'b1);
      chk("resync_ferr_once", 64'(frame_err), 64'd0);
      beat(8'h77, 1'b1); beat(8'h88, 1'b1);
      chk("resync_pdata", 64'(parallel_data), 64'h88776655);
      // Resync at frame boundary: no error
      setin(1'b1, 8'hC0, 1'b1, 1'b1);
      tick();
      chk("first_ok_ferr", 64'(frame_err), 64'd0);
      beat(8'hC1, 1'b1); beat(8'hC2, 1'b1); beat(8'hC3, 1'b1);
      chk("first_ok_pdata", 64'(parallel_data), 64'hC3C2C1C0);
      setin(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
`endif

      // Random valid/ready stress
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 599) == 0);
`ifdef SERIAL_TO_PARALLEL_FIRST_EN
         setin($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 5,
               $urandom_range(0, 15) == 0);
`else
         setin($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 5, 1'b0);
`endif
         tick();
      end
      rst = 1'b0;
      setin(1'b0, 8'h00, 1'b1, 1'b0);
      tick(); tick();
      chk("drain_pvalid", 64'(parallel_valid), 64'd0);
      chk("frames_balance", 64'(n_consumed), 64'(n_made));
      chk("frames_enough", 64'(n_made > 300), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_to_parallel.md
# serial_to_parallel

Deserializer that collects `WIDTH` consecutive `XLEN`-bit serial beats into one `WIDTH x XLEN` vector and presents it on a registered parallel output. It is the receive-side counterpart of our parallel-to-serial path: element 0 arrives first, element `WIDTH-1` last. The block sits between a serial producer and a vector consumer such as the convolution core, with valid/ready flow control on both sides. The assembly register and the output register are separate, so collection of the next frame overlaps with holding the current one.

## Interface
Parameters:
- `XLEN`, 8, bits per element.
- `WIDTH`, 16, elements per frame. Must be ≥ 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `serial_valid`  in  1  beat present on `serial_data`.
- `serial_data`  in  `XLEN`  element value.
- `serial_ready`  out  1  block accepts the beat this cycle.
- `serial_first`  in  1  beat is element 0 of a frame. Present only with `SERIAL_TO_PARALLEL_FIRST_EN`.
- `parallel_valid`  out  1  `parallel_data` holds a complete frame.
- `parallel_data`  out  `[WIDTH-1:0][XLEN-1:0]`  assembled frame, index k = k-th beat.
- `parallel_ready`  in  1  consumer takes the frame this cycle.
- `frame_err`  out  1  one-cycle pulse on resync. Present only with `SERIAL_TO_PARALLEL_FIRST_EN`.

## Operation
- Beat accepted when `serial_valid && serial_ready`. Frame accepted when `parallel_valid && parallel_ready`.
- `ptr` (`$clog2(WIDTH)` bits, 0..`WIDTH-1`) indexes the next element. An accepted beat with `ptr < WIDTH-1` writes `asm[ptr]` and increments `ptr`.
- An accepted beat with `ptr == WIDTH-1` is the final beat of the frame:
  - `parallel_data` is loaded with `asm[WIDTH-2:0]` plus the current beat in `[WIDTH-1]`.
  - `parallel_valid` is set.
  - `ptr` wraps to 0.
- `serial_ready = !(ptr == WIDTH-1 && parallel_valid && !parallel_ready)`. A final beat is stalled only while the previous frame is still unaccepted. Beats for elements 0..`WIDTH-2` are never stalled.
- When a frame is accepted and no final beat is accepted in the same cycle, `parallel_valid` clears. If both happen in the same cycle, `parallel_valid` stays 1 and `parallel_data` takes the new frame.
- `parallel_data` is stable while `parallel_valid && !parallel_ready`.
- Arithmetic: `ptr` compares against `PTR_W'(WIDTH-1)`. No padding is inserted when `WIDTH` is not a power of two.

## Timing
- Reset values:
  - `ptr = 0`.
  - `parallel_valid = 0`.
  - `parallel_data = 0`.
  - `frame_err = 0`.
  - `serial_ready` evaluates to 1 after reset.
  - `asm` is not reset.
- Latency: when the final beat is accepted in cycle N, `parallel_valid = 1` with the full vector in cycle N+1.
- Throughput: one beat per cycle, with back-to-back frames and no bubbles, while `parallel_ready` is high.
- `serial_ready` depends combinationally on `parallel_ready`. There is no path from `serial_valid` to `serial_ready`.
- Reset mid-frame discards the partial frame and any pending output frame. The first accepted beat after reset goes to index 0.
- `serial_data` is ignored when the beat is not accepted.

## Configuration
- `SERIAL_TO_PARALLEL_FIRST_EN` defined: `serial_first` and `frame_err` exist.
  - An accepted beat with `serial_first = 1` is written to `asm[0]` and sets `ptr = 1`, discarding any partial frame.
  - If `ptr != 0` at that time, `frame_err` pulses high the next cycle.
  - A first beat at `ptr == 0` behaves normally with no error.
  - `serial_first` on a beat that is not accepted has no effect.
- Undefined: both ports are absent. Framing is purely by count from reset.

## Test plan
- WIDTH=4, XLEN=8, `parallel_ready = 1`, beats 0x11,0x22,0x33,0x44 on consecutive cycles → one cycle after 0x44, `parallel_valid = 1` and `parallel_data = {0x44,0x33,0x22,0x11}` (index 0 = 0x11). `parallel_valid` drops the next cycle if no new frame is completed.
- Continuous 12-beat stream, `parallel_ready = 1` → three consecutive valid frames with `serial_ready` constantly 1.
- Hold `parallel_ready = 0` after the first frame; stream 4 more beats → beats 0..2 accepted, 4th beat stalls (`serial_ready = 0`), frame 1 data unchanged. Raise `parallel_ready` → 4th beat accepted that cycle, frame 2 valid the next cycle with no gap in `parallel_valid`.
- Assert `rst` after 2 beats, then send 4 beats 0xA0..0xA3 → output frame `{0xA3,0xA2,0xA1,0xA0}`; no residue of the pre-reset beats.
- With `SERIAL_TO_PARALLEL_FIRST_EN`: 2 beats, then `serial_first` with 0x55 plus 3 more beats → `frame_err` pulses once, output frame index 0 = 0x55. Repeat with `serial_first` at `ptr = 0` → no `frame_err`.
- Random valid/ready stress against a scoreboard model → all frames in order, no loss, no duplication.
